// File: rtl/tdm_demux1_4.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux1_4
// Description : Registered 1-to-4 time-division demultiplexer. A single
//               sample stream carrying four interleaved channels (slot 0
//               flagged by sync) is aligned, slot-counted and distributed to
//               four held channel outputs. Loss of alignment and realignment
//               are reported on err; lock shows frame alignment.
//
// Ports       : clk        rising-edge clock
//               rst        asynchronous, active-high reset
//               din        sample for the current slot (WIDTH bits)
//               din_vld    din/sync valid this cycle
//               sync       marks the accepted sample as slot 0
//               y0..y3     held channel values for slots 0..3
//               frame_vld  one-cycle pulse, a complete 4-slot frame delivered
//               lock       high while aligned to the frame
//               err        one-cycle pulse on an alignment violation
//
// Options     : TDM_DEMUX_SHADOW_EN - when defined, slots are collected in
//               shadow registers and y0..y3 update together only when a
//               frame completes. When undefined, each slot writes its output
//               directly as it arrives.
//
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux1_4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    input  logic             sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             frame_vld,
    output logic             lock,
    output logic             err
);

    localparam logic [0:0] C_ST_HUNT = 1'b0;
    localparam logic [0:0] C_ST_LOCK = 1'b1;

    localparam logic [1:0] C_SLOT_FIRST = 2'd0;
    localparam logic [1:0] C_SLOT_LAST  = 2'd3;

    logic [0:0]                 state_q, state_d;
    logic [1:0]                 slot_q, slot_d;
    logic [3:0][WIDTH-1:0]      y_q, y_d;
    logic                       frame_vld_q, frame_vld_d;
    logic                       err_q, err_d;
    logic                       lock_q, lock_d;

    // Decoded per-sample actions from the next-state logic
    logic                       w_wr_en;
    logic [1:0]                 w_wr_slot;
    logic                       w_align_err;

`ifdef TDM_DEMUX_SHADOW_EN
    // Slot 3 never needs a shadow: it is taken straight from din on the
    // completing edge.
    logic [2:0][WIDTH-1:0]      sh_q, sh_d;
`endif

    // ------------------------------------------------------------------------
    // State register (all flops of the block)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= C_ST_HUNT;
            slot_q      <= C_SLOT_FIRST;
            y_q         <= '0;
            frame_vld_q <= 1'b0;
            err_q       <= 1'b0;
            lock_q      <= 1'b0;
`ifdef TDM_DEMUX_SHADOW_EN
            sh_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            y_q         <= y_d;
            frame_vld_q <= frame_vld_d;
            err_q       <= err_d;
            lock_q      <= lock_d;
`ifdef TDM_DEMUX_SHADOW_EN
            sh_q        <= sh_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic: alignment decisions and slot counting
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        w_wr_en     = 1'b0;
        w_wr_slot   = C_SLOT_FIRST;
        w_align_err = 1'b0;

        if (din_vld) begin
            if (state_q == C_ST_HUNT) begin
                // Anything before the first sync is dropped silently.
                if (sync) begin
                    w_wr_en = 1'b1;
                    slot_d  = 2'd1;
                    state_d = C_ST_LOCK;
                end
            end else begin
                if (sync) begin
                    // A sync anywhere but slot 0 restarts the frame here;
                    // a sync on slot 3 falls in this class, so a completing
                    // write never coincides with an error.
                    w_align_err = (slot_q != C_SLOT_FIRST);
                    w_wr_en     = 1'b1;
                    slot_d      = 2'd1;
                end else if (slot_q != C_SLOT_FIRST) begin
                    w_wr_en   = 1'b1;
                    w_wr_slot = slot_q;
                    slot_d    = slot_q + 2'd1;
                end else begin
                    // Expected sync is missing: alignment is lost.
                    w_align_err = 1'b1;
                    slot_d      = C_SLOT_FIRST;
                    state_d     = C_ST_HUNT;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // ------------------------------------------------------------------------
    always_comb begin
        frame_vld_d = w_wr_en && (w_wr_slot == C_SLOT_LAST);
        err_d       = w_align_err;
        lock_d      = (state_d == C_ST_LOCK);
        y_d         = y_q;

`ifdef TDM_DEMUX_SHADOW_EN
        sh_d = sh_q;
        if (w_wr_en && (w_wr_slot != C_SLOT_LAST)) begin
            sh_d[w_wr_slot] = din;
        end
        if (frame_vld_d) begin
            y_d = {din, sh_q[2], sh_q[1], sh_q[0]};
        end
`else
        if (w_wr_en) begin
            y_d[w_wr_slot] = din;
        end
`endif
    end

    assign y0        = y_q[0];
    assign y1        = y_q[1];
    assign y2        = y_q[2];
    assign y3        = y_q[3];
    assign frame_vld = frame_vld_q;
    assign err       = err_q;
    assign lock      = lock_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux1_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux1_4
// Description : Directed self-checking bench for tdm_demux1_4 (WIDTH = 4).
//               Expected values are hand-computed; expectations that differ
//               between the per-slot and shadow builds follow
//               TDM_DEMUX_SHADOW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux1_4;

    localparam int WIDTH = 4;
`ifdef TDM_DEMUX_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             din_vld = 1'b0;
    logic             sync = 1'b0;
    logic [WIDTH-1:0] y0, y1, y2, y3;
    logic             frame_vld, lock, err;

    int n_checks = 0;
    int n_fail   = 0;

    tdm_demux1_4 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_vld   (din_vld),
        .sync      (sync),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .frame_vld (frame_vld),
        .lock      (lock),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs away from the edge, then land just after it.
    task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d);
        @(negedge clk);
        din_vld = v;
        sync    = s;
        din     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_y(input string tag, input logic [15:0] exp);
        chk({tag, "_y0"}, 32'(y0), 32'(exp[3:0]));
        chk({tag, "_y1"}, 32'(y1), 32'(exp[7:4]));
        chk({tag, "_y2"}, 32'(y2), 32'(exp[11:8]));
        chk({tag, "_y3"}, 32'(y3), 32'(exp[15:12]));
    endtask

    task automatic chk_flags(input string tag, input logic fv, input logic lk, input logic er);
        chk({tag, "_frame_vld"}, 32'(frame_vld), 32'(fv));
        chk({tag, "_lock"},      32'(lock),      32'(lk));
        chk({tag, "_err"},       32'(err),       32'(er));
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk_y("reset", 16'h0000);
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- first frame 1,2,3,4 ----------------
        step(1'b1, 1'b1, 4'h1);
        chk_flags("f1_s0", 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'h2);
        chk_flags("f1_s1", 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'h3);
        chk_flags("f1_s2", 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'h4);
        chk_flags("f1_s3", 1'b1, 1'b1, 1'b0);
        chk_y("f1", 16'h4321);
        step(1'b0, 1'b0, 4'h0);
        chk_flags("f1_idle", 1'b0, 1'b1, 1'b0);

        // ---------------- HUNT drops unsynced sample ----------------
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 4'hF);
        chk_y("hunt_drop", 16'h0000);
        chk_flags("hunt_drop", 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'h5);
        chk("f2_s0_lock", 32'(lock), 32'd1);
        step(1'b1, 1'b0, 4'h6);
        step(1'b1, 1'b0, 4'h7);
        step(1'b1, 1'b0, 4'h8);
        chk_flags("f2_s3", 1'b1, 1'b1, 1'b0);
        chk_y("f2", 16'h8765);

        // ---------------- early sync ----------------
        step(1'b1, 1'b1, 4'hA);
        step(1'b1, 1'b0, 4'hB);
        step(1'b1, 1'b1, 4'hC);
        chk_flags("early", 1'b0, 1'b1, 1'b1);
        chk_y("early", SHADOW ? 16'h8765 : 16'h87BC);
        step(1'b0, 1'b0, 4'h0);
        chk_flags("early_idle", 1'b0, 1'b1, 1'b0);
        // Finish the restarted frame so slot returns to 0.
        step(1'b1, 1'b0, 4'hD);
        step(1'b1, 1'b0, 4'hE);
        step(1'b1, 1'b0, 4'h1);
        chk_flags("f3_s3", 1'b1, 1'b1, 1'b0);
        chk_y("f3", 16'h1EDC);

        // ---------------- missing sync ----------------
        step(1'b1, 1'b0, 4'h9);
        chk_flags("missing", 1'b0, 1'b0, 1'b1);
        chk_y("missing", 16'h1EDC);
        step(1'b0, 1'b0, 4'h0);
        chk_flags("missing_idle", 1'b0, 1'b0, 1'b0);

        // ---------------- frame with gaps ----------------
        step(1'b1, 1'b1, 4'h2);
        step(1'b1, 1'b0, 4'h3);
        for (int i = 0; i < 3; i++) begin
            // sync and din toggled while invalid must be ignored
            step(1'b0, 1'b1, 4'hF);
            chk_flags("gap", 1'b0, 1'b1, 1'b0);
        end
        step(1'b1, 1'b0, 4'h4);
        chk("gap_s2_fv", 32'(frame_vld), 32'd0);
        step(1'b1, 1'b0, 4'h5);
        chk_flags("gap_s3", 1'b1, 1'b1, 1'b0);
        chk_y("gap", 16'h5432);

        // ---------------- asynchronous reset mid-frame ----------------
        step(1'b1, 1'b1, 4'h6);
        step(1'b1, 1'b0, 4'h7);
        step(1'b1, 1'b0, 4'h8);
        @(negedge clk);
        din_vld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_y("async_rst", 16'h0000);
        chk_flags("async_rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1, 4'h9);
        step(1'b1, 1'b0, 4'hA);
        step(1'b1, 1'b0, 4'hB);
        chk("post_rst_s2_fv", 32'(frame_vld), 32'd0);
        step(1'b1, 1'b0, 4'hC);
        chk_flags("post_rst_s3", 1'b1, 1'b1, 1'b0);
        chk_y("post_rst", 16'hCBA9);
        step(1'b0, 1'b0, 4'h0);
        chk("post_rst_idle_fv", 32'(frame_vld), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
